// File: rtl/wbmic_ctrl.sv
// Wishbone sampling controller for the PMod MIC ADC; feeds samples to an external FIFO.
// Optional interrupt logic is compiled in when WBMIC_INTERRUPT_EN is defined.
module wbmic_ctrl #(
    parameter int unsigned SCKDIV = 4,
    parameter int unsigned DIVW   = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_csn,
    output logic        o_sck,
    input  logic        i_miso,
    output logic        o_fifo_rst,
    output logic        o_fifo_wr,
    output logic [11:0] o_fifo_data,
    output logic        o_fifo_rd,
    input  logic        i_fifo_empty_n,
    input  logic [11:0] i_fifo_data,
    input  logic [15:0] i_fifo_status,
    input  logic        i_fifo_err,
    output logic        o_int
);

    localparam int unsigned SW = (SCKDIV > 1) ? $clog2(SCKDIV) : 1;
    localparam logic [SW-1:0] SubLast = SW'(SCKDIV - 1);

    typedef enum logic [1:0] {StIdle, StConv, StQuiet} state_e;

    logic wb_req, wr_req, rd_req, wr_ctrl;
    logic en_q, en_d;
    logic late_q, late_d, late_clr;
    logic [DIVW-1:0] div_q, div_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic tick;
    logic fifo_rst_q, fifo_rst_d;
    logic ack_q;
    logic [31:0] rdata_q, rdata_d;
    logic int_en_rd;

    state_e state_q, state_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [4:0] half_q, half_d;
    logic [11:0] shift_q, shift_d;
    logic csn_q, csn_d;
    logic sck_q, sck_d;
    logic wr_q, wr_d;
    logic [11:0] fdata_q, fdata_d;

    // Bits 27:20 of control writes carry nothing; fold all write data into an unused sink.
    logic unused_wdata;
    assign unused_wdata = ^i_wb_data;

    assign wb_req  = i_wb_cyc & i_wb_stb;
    assign wr_req  = wb_req & i_wb_we;
    assign rd_req  = wb_req & ~i_wb_we;
    assign wr_ctrl = wr_req && (i_wb_addr == 2'd0);

    assign o_wb_ack    = ack_q;
    assign o_wb_stall  = 1'b0;
    assign o_wb_data   = rdata_q;
    assign o_csn       = csn_q;
    assign o_sck       = sck_q;
    assign o_fifo_rst  = fifo_rst_q;
    assign o_fifo_wr   = wr_q;
    assign o_fifo_data = fdata_q;
    assign o_fifo_rd   = rd_req && (i_wb_addr == 2'd2) && i_fifo_empty_n;

    always_comb begin
        en_d       = en_q;
        div_d      = div_q;
        fifo_rst_d = 1'b0;
        late_clr   = 1'b0;
        if (wr_ctrl) begin
            en_d       = i_wb_data[31];
            fifo_rst_d = i_wb_data[29];
            late_clr   = i_wb_data[28];
        end
        if (wr_req && (i_wb_addr == 2'd1)) begin
            div_d = i_wb_data[DIVW-1:0];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_req) begin
            unique case (i_wb_addr)
                2'd0:    rdata_d = {en_q, int_en_rd, i_fifo_err, late_q, 12'h000, i_fifo_status};
                2'd1:    rdata_d = 32'(div_q);
                2'd2:    rdata_d = {i_fifo_empty_n, 19'h00000, i_fifo_data};
                default: rdata_d = 32'h0000_0000;
            endcase
        end
    end

    // Pacing counter: held at the divider value while disabled, so enabling starts a full period.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!en_q) begin
            cnt_d = div_q;
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = div_q;
        end else begin
            cnt_d = cnt_q - DIVW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        half_d  = half_q;
        shift_d = shift_q;
        csn_d   = csn_q;
        sck_d   = sck_q;
        wr_d    = 1'b0;
        fdata_d = fdata_q;
        late_d  = late_q;
        if (tick && (state_q != StIdle)) begin
            late_d = 1'b1;
        end
        if (late_clr) begin
            late_d = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                csn_d  = 1'b1;
                sck_d  = 1'b1;
                sub_d  = '0;
                half_d = '0;
                if (tick) begin
                    state_d = StConv;
                    csn_d   = 1'b0;
                end
            end
            StConv: begin
                if (!en_d) begin
                    state_d = StQuiet;
                    csn_d   = 1'b1;
                    sck_d   = 1'b1;
                    sub_d   = '0;
                end else if (sub_q == SubLast) begin
                    sub_d  = '0;
                    half_d = half_q + 5'd1;
                    sck_d  = ~sck_q;
                    // Odd half-periods are SCK low; their end is a rising edge.
                    if (half_q[0]) begin
                        shift_d = {shift_q[10:0], i_miso};
                    end
                    if (half_q == 5'd31) begin
                        state_d = StQuiet;
                        csn_d   = 1'b1;
                        sck_d   = 1'b1;
                        wr_d    = 1'b1;
                        fdata_d = shift_d;
                    end
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end
            StQuiet: begin
                if (sub_q == SubLast) begin
                    state_d = StIdle;
                    sub_d   = '0;
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q       <= 1'b0;
            late_q     <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            fifo_rst_q <= 1'b1;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            state_q    <= StIdle;
            sub_q      <= '0;
            half_q     <= '0;
            shift_q    <= '0;
            csn_q      <= 1'b1;
            sck_q      <= 1'b1;
            wr_q       <= 1'b0;
            fdata_q    <= '0;
        end else begin
            en_q       <= en_d;
            late_q     <= late_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            fifo_rst_q <= fifo_rst_d;
            ack_q      <= wb_req;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            sub_q      <= sub_d;
            half_q     <= half_d;
            shift_q    <= shift_d;
            csn_q      <= csn_d;
            sck_q      <= sck_d;
            wr_q       <= wr_d;
            fdata_q    <= fdata_d;
        end
    end

`ifdef WBMIC_INTERRUPT_EN
    logic int_en_q, int_en_d;
    logic int_q, int_d;

    always_comb begin
        int_en_d = int_en_q;
        if (wr_ctrl) begin
            int_en_d = i_wb_data[30];
        end
        int_d = int_en_q & (i_fifo_status[1] | i_fifo_err);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            int_en_q <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            int_en_q <= int_en_d;
            int_q    <= int_d;
        end
    end

    assign int_en_rd = int_en_q;
    assign o_int     = int_q;
`else
    assign int_en_rd = 1'b0;
    assign o_int     = 1'b0;
`endif

endmodule

// File: tb/tb_wbmic_ctrl.sv
// Directed bench for wbmic_ctrl: register map, frame timing, FIFO pops, late flag, abort, reset.
module tb_wbmic_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rdata;
    logic        csn, sck, miso;
    logic        fifo_rst, fifo_wr, fifo_rd;
    logic [11:0] fifo_wdata;
    logic        fifo_empty_n;
    logic [11:0] fifo_head;
    logic [15:0] fifo_status;
    logic        fifo_err;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    wbmic_ctrl #(.SCKDIV(4), .DIVW(20)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wb_cyc       (wb_cyc),
        .i_wb_stb       (wb_stb),
        .i_wb_we        (wb_we),
        .i_wb_addr      (wb_addr),
        .i_wb_data      (wb_wdata),
        .o_wb_ack       (wb_ack),
        .o_wb_stall     (wb_stall),
        .o_wb_data      (wb_rdata),
        .o_csn          (csn),
        .o_sck          (sck),
        .i_miso         (miso),
        .o_fifo_rst     (fifo_rst),
        .o_fifo_wr      (fifo_wr),
        .o_fifo_data    (fifo_wdata),
        .o_fifo_rd      (fifo_rd),
        .i_fifo_empty_n (fifo_empty_n),
        .i_fifo_data    (fifo_head),
        .i_fifo_status  (fifo_status),
        .i_fifo_err     (fifo_err),
        .o_int          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: frame k shifts out 16'h0ABC + k, MSB first, advancing after each SCK rise.
    logic [3:0]  bit_idx = 4'd0;
    logic [7:0]  frame_cnt = 8'd0;
    logic [15:0] adc_pat;
    assign adc_pat = 16'h0ABC + {8'h00, frame_cnt};
    assign miso = adc_pat[4'd15 - bit_idx];

    always @(posedge sck or posedge csn) begin
        if (csn) bit_idx <= 4'd0;
        else     bit_idx <= bit_idx + 4'd1;
    end

    // FIFO model plus event counters.
    logic [11:0] fmem [0:15];
    logic [4:0]  wp = 5'd0;
    logic [4:0]  rp = 5'd0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int csl_run = 0;
    int csl_last = 0;

    assign fifo_empty_n = (wp != rp);
    assign fifo_head    = fifo_empty_n ? fmem[rp[3:0]] : 12'h000;

    always @(posedge clk) begin
        if (fifo_rst) begin
            wp <= 5'd0;
            rp <= 5'd0;
        end else begin
            if (fifo_wr) begin
                fmem[wp[3:0]] <= fifo_wdata;
                wp <= wp + 5'd1;
            end
            if (fifo_rd) rp <= rp + 5'd1;
        end
        if (fifo_wr) begin
            wr_cnt    <= wr_cnt + 1;
            frame_cnt <= frame_cnt + 8'd1;
        end
        if (fifo_rd) rd_cnt <= rd_cnt + 1;
        if (!csn) begin
            csl_run <= csl_run + 1;
        end else if (csl_run != 0) begin
            csl_last <= csl_run;
            csl_run  <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        step(1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check_eq("wr_ack", {31'd0, wb_ack}, 32'd1);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
        step(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        d = wb_rdata;
        check_eq("rd_ack", {31'd0, wb_ack}, 32'd1);
    endtask

    task automatic wait_wr(input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (fifo_wr) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic wait_csn_low(input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (!csn) begin
                waited = i;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    logic [31:0] burst [0:3];
    int w, wc, rc;

    initial begin
        rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 2'd0; wb_wdata = '0;
        fifo_status = 16'h0000;
        fifo_err = 1'b0;
        step(3);
        check_eq("rst_outs", {25'd0, csn, sck, fifo_rst, fifo_wr, wb_ack, irq, wb_stall},
                 {25'd0, 7'b1110000});
        rst_n = 1'b1;
        check_eq("fifo_rst_hold", {31'd0, fifo_rst}, 32'd1);
        step(1);
        check_eq("fifo_rst_rel", {31'd0, fifo_rst}, 32'd0);

        wb_read(2'd0, rd); check_eq("ctrl_rst", rd, 32'h0000_0000);
        wb_read(2'd1, rd); check_eq("div_rst", rd, 32'h0000_0000);
        wb_read(2'd3, rd); check_eq("addr3", rd, 32'h0000_0000);
        wb_write(2'd1, 32'hFFFF_FFFF);
        wb_read(2'd1, rd); check_eq("div_mask", rd, 32'h000F_FFFF);
        wb_write(2'd1, 32'd199);
        wb_read(2'd1, rd); check_eq("div_199", rd, 32'd199);

        // Frames at divider 199: first write 1 + 199 + 1 + 128 - 1 edges after enable.
        wb_write(2'd0, 32'h8000_0000);
        wait_wr(400, w);
        check_eq("first_wr_lat", w, 328);
        check_eq("sample1", {20'd0, fifo_wdata}, 32'h0000_0ABC);
        wait_wr(400, w);
        check_eq("period2", w, 200);
        check_eq("sample2", {20'd0, fifo_wdata}, 32'h0000_0ABD);
        wait_wr(400, w);
        check_eq("period3", w, 200);
        check_eq("sample3", {20'd0, fifo_wdata}, 32'h0000_0ABE);
        step(1);
        check_eq("wr_width", {31'd0, fifo_wr}, 32'd0);
        check_eq("cs_low_len", csl_last, 128);
        wb_write(2'd0, 32'h0000_0000);
        check_eq("wr_count3", wr_cnt, 3);
        wb_read(2'd0, rd); check_eq("no_late", rd, 32'h0000_0000);

        // Four back-to-back popping reads against three queued samples.
        step(5);
        rc = rd_cnt;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd2;
        for (int i = 0; i < 4; i++) begin
            step(1);
            burst[i] = wb_rdata;
            check_eq("burst_ack", {31'd0, wb_ack}, 32'd1);
            if (i == 3) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
        end
        check_eq("pop0", burst[0], 32'h8000_0ABC);
        check_eq("pop1", burst[1], 32'h8000_0ABD);
        check_eq("pop2", burst[2], 32'h8000_0ABE);
        check_eq("pop3", burst[3], 32'h0000_0000);
        check_eq("rd_pulses", rd_cnt - rc, 3);

        // Divider shorter than the busy time sets the late flag.
        wb_write(2'd1, 32'd50);
        wb_write(2'd0, 32'h8000_0000);
        step(300);
        wb_read(2'd0, rd); check_eq("late_set", rd, 32'h9000_0000);
        wb_write(2'd0, 32'h1000_0000);
        wb_read(2'd0, rd); check_eq("late_clr", rd, 32'h0000_0000);

        step(10);
        wb_write(2'd0, 32'h2000_0000);
        check_eq("fifo_rst_pulse", {31'd0, fifo_rst}, 32'd1);
        step(1);
        check_eq("fifo_rst_end", {31'd0, fifo_rst}, 32'd0);
        wb_read(2'd2, rd); check_eq("fifo_cleared", rd, 32'h0000_0000);

        // Disable 40 clocks into a conversion.
        wb_write(2'd1, 32'd199);
        wb_write(2'd0, 32'h8000_0000);
        wait_csn_low(400, w);
        check_eq("abort_cs_seen", {31'd0, w > 0}, 32'd1);
        step(40);
        wc = wr_cnt;
        wb_write(2'd0, 32'h0000_0000);
        check_eq("abort_csn_sck", {30'd0, csn, sck}, 32'd3);
        step(400);
        check_eq("abort_no_wr", wr_cnt, wc);

`ifdef WBMIC_INTERRUPT_EN
        wb_write(2'd0, 32'h4000_0000);
        fifo_status = 16'h0002;
        check_eq("int_pre", {31'd0, irq}, 32'd0);
        step(1);
        check_eq("int_rise", {31'd0, irq}, 32'd1);
        wb_read(2'd0, rd); check_eq("int_en_rb", rd, 32'h4000_0002);
        wb_write(2'd0, 32'h0000_0000);
        step(1);
        check_eq("int_fall", {31'd0, irq}, 32'd0);
`else
        wb_write(2'd0, 32'h4000_0000);
        fifo_status = 16'h0002;
        step(3);
        check_eq("int_off", {31'd0, irq}, 32'd0);
        wb_read(2'd0, rd); check_eq("int_en_rb0", rd, 32'h0000_0002);
`endif
        fifo_status = 16'h0000;

        // Asynchronous reset in the middle of a conversion.
        wb_write(2'd0, 32'h8000_0000);
        wait_csn_low(400, w);
        check_eq("rst_cs_seen", {31'd0, w > 0}, 32'd1);
        step(20);
        wc = wr_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_outs", {28'd0, csn, sck, fifo_rst, fifo_wr}, 32'hE);
        step(3);
        check_eq("midrst_hold", {28'd0, csn, sck, fifo_rst, fifo_wr}, 32'hE);
        rst_n = 1'b1;
        step(1);
        check_eq("midrst_rel", {31'd0, fifo_rst}, 32'd0);
        step(400);
        check_eq("midrst_no_wr", wr_cnt, wc);
        wb_read(2'd0, rd); check_eq("midrst_ctrl", rd, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
